// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states, constants.
// HILO_MADD_EN enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package hilo_pkg;

  localparam int unsigned HILO_WIDTH = 32;
  localparam logic [63:0] DIV0_LO    = '1;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9,
    OP_NOP   = 4'd15
  } op_t;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  function automatic logic is_iter(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath: shift-add multiply / restoring divide on operand magnitudes,
// with sign fixup applied combinationally to the final accumulator.
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             signed_op,
  input  logic             div_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc_q, acc_d, prod_fix;
  logic [WIDTH-1:0]   m_q, m_d, mag_a, mag_b;
  logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               a_neg, b_neg;
  logic [WIDTH:0]     add_sum, rem_sh, diff;

  always_comb begin
    a_neg   = signed_op & a[WIDTH-1];
    b_neg   = signed_op & b[WIDTH-1];
    mag_a   = a_neg ? -a : a;
    mag_b   = b_neg ? -b : b;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    // divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
    rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, m_q};

    acc_d    = acc_q;
    m_d      = m_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (load) begin
      m_d      = div_op ? mag_b : mag_a;
      acc_d    = {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
      div_d    = div_op;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = div_op ? a_neg : (a_neg ^ b_neg);
    end else if (step) begin
      if (div_q)
        acc_d = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~diff[WIDTH]};
      else
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    if (div_q) begin
      res_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      m_q      <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner with iterative MULT/DIV, MTHI/MTLO and forwarding outputs.
// HILO_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulating into {HI,LO}.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = HILO_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             fwd_hi_src,
  output logic [WIDTH-1:0] fwd_hi_data,
  output logic             fwd_lo_src,
  output logic [WIDTH-1:0] fwd_lo_data
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_d, lo_d, a_q, a_d, res_hi, res_lo;
  logic             div0_q, div0_d, accept, hi_wr, lo_wr;
`ifdef HILO_MADD_EN
  logic             acc_en_q, acc_en_d, acc_sub_q, acc_sub_d;
`endif

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state_q == RUN),
    .signed_op (is_signed_op(op)),
    .div_op    (is_div_op(op)),
    .a         (src_a),
    .b         (src_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_comb begin
    accept  = start && !flush && (state_q == IDLE) && is_iter(op);
    busy    = (start && is_iter(op)) || (state_q != IDLE);
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    done    = 1'b0;
`ifdef HILO_MADD_EN
    acc_en_d  = acc_en_q;
    acc_sub_d = acc_sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = src_a;
          cnt_d   = '0;
          div0_d  = is_div_op(op) && (src_b == '0);
          state_d = div0_d ? FIX : RUN;
`ifdef HILO_MADD_EN
          acc_en_d  = op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
          acc_sub_d = op inside {OP_MSUB, OP_MSUBU};
`endif
        end else if (start && !flush && op == OP_MTHI) begin
          hi_wr = 1'b1;
          hi_d  = src_a;
        end else if (start && !flush && op == OP_MTLO) begin
          lo_wr = 1'b1;
          lo_d  = src_a;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done  = 1'b1;
          hi_wr = 1'b1;
          lo_wr = 1'b1;
          if (div0_q) begin
            hi_d = a_q;
            lo_d = DIV0_LO[WIDTH-1:0];
          end else begin
            {hi_d, lo_d} = {res_hi, res_lo};
`ifdef HILO_MADD_EN
            if (acc_en_q)
              {hi_d, lo_d} = acc_sub_q ? ({hi_q, lo_q} - {res_hi, res_lo})
                                       : ({hi_q, lo_q} + {res_hi, res_lo});
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    fwd_hi_src  = hi_wr;
    fwd_lo_src  = lo_wr;
    fwd_hi_data = hi_wr ? hi_d : '0;
    fwd_lo_data = lo_wr ? lo_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef HILO_MADD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
    end else begin
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
    end
  end
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: vector table, randomized ops against an arithmetic model,
// and hand sequences for flush, reset and forwarding corner cases.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = OP_NOP;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done, fwd_hi_src, fwd_lo_src;
  logic [31:0] hi_q, lo_q, fwd_hi_data, fwd_lo_data;

  int tests = 0;
  int fails = 0;
  logic [63:0] mdl;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .hi_q(hi_q), .lo_q(lo_q),
    .fwd_hi_src(fwd_hi_src), .fwd_hi_data(fwd_hi_data),
    .fwd_lo_src(fwd_lo_src), .fwd_lo_data(fwd_lo_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, eh, el;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour straight from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    int sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  return longint'(sa) * longint'(sb);
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MADD, OP_MSUB: begin
        p = longint'(sa) * longint'(sb);
        return (o == OP_MADD) ? hilo + p : hilo - p;
      end
      OP_MADDU, OP_MSUBU: begin
        p = {32'h0, a} * {32'h0, b};
        return (o == OP_MADDU) ? hilo + p : hilo - p;
      end
      default: return hilo;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
    int lat;
    bit gap;
    logic fsrc;
    logic [31:0] fh, fl;
    lat = 0; gap = 0; fsrc = 0; fh = '0; fl = '0;
    next_cycle();
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    chk({nm, " busy_start"}, 64'(busy), 64'(1));
    next_cycle();
    start = 1'b0; op = OP_NOP; src_a = $urandom; src_b = $urandom;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!busy) gap = 1;
      if (done) begin
        lat = k; fh = fwd_hi_data; fl = fwd_lo_data; fsrc = fwd_hi_src & fwd_lo_src;
        break;
      end
      next_cycle();
    end
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " busy_hold"}, 64'(gap), 64'(0));
    chk({nm, " fwd"}, {31'h0, fsrc, fh, fl}, {31'h0, 1'b1, eh, el});
    next_cycle();
    @(negedge clk);
    chk({nm, " hilo"}, {hi_q, lo_q}, {eh, el});
    chk({nm, " busy_after"}, 64'(busy), 64'(0));
    mdl = {hi_q, lo_q};
    mdl = {eh, el};
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] d);
    next_cycle();
    start = 1'b1; op = o; src_a = d;
    @(negedge clk);
    if (o == OP_MTHI) chk("mthi fwd", {31'h0, fwd_hi_src, fwd_hi_data}, {31'h0, 1'b1, d});
    else              chk("mtlo fwd", {31'h0, fwd_lo_src, fwd_lo_data}, {31'h0, 1'b1, d});
    chk("mt busy_done", {busy, done}, 64'(0));
    next_cycle();
    start = 1'b0; op = OP_NOP;
    @(negedge clk);
    if (o == OP_MTHI) mdl[63:32] = d; else mdl[31:0] = d;
    chk("mt hilo", {hi_q, lo_q}, mdl);
  endtask

  vec_t vecs[10];

  initial begin
    logic [3:0] o;
    logic [31:0] a, b;
    logic [63:0] e;
    bit seen;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 33};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 33};
    vecs[5] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        33};
    vecs[9] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,        32'h0,         33};

    #12;
    chk("reset outputs", {30'h0, busy, done, fwd_hi_src, fwd_lo_src}, 64'(0));
    chk("reset hilo", {hi_q, lo_q}, 64'(0));
    chk("reset fwd data", {fwd_hi_data, fwd_lo_data}, 64'(0));
    next_cycle();
    rst = 1'b0;
    mdl = '0;

    mt(OP_MTHI, 32'h1234_5678);
    mt(OP_MTLO, 32'h9ABC_DEF0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, vecs[i].lat);

    for (int i = 0; i < 30; i++) begin
`ifdef HILO_MADD_EN
      o = 4'($urandom_range(0, 7));
      if (o >= 4) o = o + 4'd2;
`else
      o = 4'($urandom_range(0, 3));
`endif
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 1;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(2, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      e = model(o, a, b, mdl);
      run_op($sformatf("rnd%0d op%0d", i, o), o, a, b, e[63:32], e[31:0],
             ((o == OP_DIV || o == OP_DIVU) && b == 0) ? 1 : 33);
    end

    // flush during RUN, then MTLO right after
    mt(OP_MTHI, 32'h0BAD_CAFE);
    next_cycle();
    start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      start = 1'b0; op = OP_NOP;
      flush = (k == 10);
      @(negedge clk);
      if (done) seen = 1;
    end
    next_cycle();
    flush = 1'b0; start = 1'b1; op = OP_MTLO; src_a = 32'hCAFE_F00D;
    @(negedge clk);
    chk("flush busy_n11", 64'(busy), 64'(0));
    chk("flush hilo_kept", {hi_q, lo_q}, mdl);
    next_cycle();
    start = 1'b0; op = OP_NOP;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      next_cycle();
    end
    chk("flush no_done", 64'(seen), 64'(0));
    mdl[31:0] = 32'hCAFE_F00D;
    chk("flush mtlo_accept", {hi_q, lo_q}, mdl);

    // flush in FIX: done forced low, no write
    next_cycle();
    start = 1'b1; op = OP_MULTU; src_a = 32'd5; src_b = 32'd6;
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      start = 1'b0; op = OP_NOP;
      flush = (k == 33);
    end
    @(negedge clk);
    chk("fix flush done", {done, fwd_hi_src, fwd_lo_src}, 64'(0));
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("fix flush hilo", {hi_q, lo_q}, mdl);
    chk("fix flush busy", 64'(busy), 64'(0));

    // start while busy is ignored
    next_cycle();
    start = 1'b1; op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
    next_cycle();
    next_cycle();
    op = OP_MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("busy start_ignored fwd", 64'(fwd_hi_src), 64'(0));
    next_cycle();
    start = 1'b0; op = OP_NOP;
    @(negedge clk);
    chk("busy start_ignored hi", 64'(hi_q), 64'(mdl[63:32]));

    // asynchronous reset mid-operation
    for (int k = 0; k < 40; k++) next_cycle();
    mdl = 64'd81;
    chk("pre-rst hilo", {hi_q, lo_q}, mdl);
    next_cycle();
    start = 1'b1; op = OP_MULT; src_a = 32'd11; src_b = 32'd13;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      start = 1'b0; op = OP_NOP;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst hilo", {hi_q, lo_q}, 64'(0));
    chk("rst busy", {busy, done}, 64'(0));
    next_cycle();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
      next_cycle();
    end
    chk("rst quiet", 64'(seen) | {hi_q, lo_q}, 64'(0));
    mdl = '0;

`ifdef HILO_MADD_EN
    mt(OP_MTHI, 32'h0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
    run_op("madd", OP_MADD, 32'd2, 32'd3, 32'd1, 32'd5, 33);
    run_op("msubu", OP_MSUBU, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF, 33);
`else
    mt(OP_MTHI, 32'h5555_AAAA);
    next_cycle();
    start = 1'b1; op = OP_MADD; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    chk("madd off busy", {busy, fwd_hi_src, fwd_lo_src}, 64'(0));
    next_cycle();
    start = 1'b0; op = OP_NOP;
    @(negedge clk);
    chk("madd off hilo", {hi_q, lo_q}, mdl);
    chk("madd off idle", {busy, done}, 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
